// File: rtl/cond_logic.sv
// cond_logic: condition-field evaluation, NZCV flag register, write-strobe
// gating and saturating debug statistics for the single-cycle ARM datapath.
module cond_logic #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr_cnt,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] RetiredCnt,
  output logic [CNT_W-1:0] SquashedCnt,
  output logic [CNT_W-1:0] TakenBrCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic flag_n, flag_z, flag_c, flag_v;
  logic wr_nz, wr_cv;

  assign flag_n = Flags[3];
  assign flag_z = Flags[2];
  assign flag_c = Flags[1];
  assign flag_v = Flags[0];

  // Condition check uses only the registered flags, so a flag-setting
  // instruction is judged against the flags that existed before it.
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = flag_z;
      4'b0001: CondEx = ~flag_z;
      4'b0010: CondEx = flag_c;
      4'b0011: CondEx = ~flag_c;
      4'b0100: CondEx = flag_n;
      4'b0101: CondEx = ~flag_n;
      4'b0110: CondEx = flag_v;
      4'b0111: CondEx = ~flag_v;
      4'b1000: CondEx = flag_c & ~flag_z;
      4'b1001: CondEx = ~flag_c | flag_z;
      4'b1010: CondEx = (flag_n == flag_v);
      4'b1011: CondEx = (flag_n != flag_v);
      4'b1100: CondEx = ~flag_z & (flag_n == flag_v);
      4'b1101: CondEx = flag_z | (flag_n != flag_v);
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  assign PCSrc    = PCS  & CondEx & en;
  assign RegWrite = RegW & CondEx & en;
  assign MemWrite = MemW & CondEx & en;

  assign wr_nz = en & FlagW[1] & CondEx;
  assign wr_cv = en & FlagW[0] & CondEx;

  // NZ and CV halves are written independently; each holds unless enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else begin
      if (wr_nz) Flags[3:2] <= ALUFlags[3:2];
      if (wr_cv) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    if (inc && (v != CNT_MAX)) return v + CNT_ONE;
    return v;
  endfunction

  // Statistics counters: clear wins over counting, stall freezes, never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RetiredCnt  <= '0;
      SquashedCnt <= '0;
      TakenBrCnt  <= '0;
    end else if (clr_cnt) begin
      RetiredCnt  <= '0;
      SquashedCnt <= '0;
      TakenBrCnt  <= '0;
    end else if (en) begin
      RetiredCnt  <= sat_inc(RetiredCnt, CondEx);
      SquashedCnt <= sat_inc(SquashedCnt, ~CondEx);
      TakenBrCnt  <= sat_inc(TakenBrCnt, PCSrc);
    end
  end

endmodule
